// File: rtl/cell_pkg.sv
// Shared types for the cell access controller: FSM states, the cell-phase
// encodings seen on {valid, rw}, and the address-width helper.
package cell_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT_W = 3'd2,
    WAIT_S = 3'd3,
    WAIT_R = 3'd4,
    FIN    = 3'd5
  } state_e;

  // {valid, rw} as driven by the selected cell's own FSM
  localparam logic [1:0] PH_WRITE  = 2'b11;
  localparam logic [1:0] PH_READ   = 2'b10;
  localparam logic [1:0] PH_STABLE = 2'b01;

  function automatic int addr_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cell_access_ctrl_if.sv
// Bus-side and cell-side signal bundle of the cell access controller.
// The controller is the slave; requesters plus the cell array form the master side.
interface cell_access_ctrl_if #(
  parameter int N_CELLS = 16
);
  localparam int ADDR_W = cell_pkg::addr_width(N_CELLS);

  logic [1:0]         req;
  logic [1:0]         we;
  logic [ADDR_W-1:0]  addr0;
  logic [ADDR_W-1:0]  addr1;
  logic [1:0]         wdata;
  logic [1:0]         gnt;
  logic [1:0]         done;
  logic               err;
  logic               rdata;
  logic [N_CELLS-1:0] cell_sel;
  logic               cell_op;
  logic               cell_din;
  logic               cell_dout;
  logic               cell_valid;
  logic               cell_rw;

  modport master (
    output req, we, addr0, addr1, wdata, cell_dout, cell_valid, cell_rw,
    input  gnt, done, err, rdata, cell_sel, cell_op, cell_din
  );

  modport slave (
    input  req, we, addr0, addr1, wdata, cell_dout, cell_valid, cell_rw,
    output gnt, done, err, rdata, cell_sel, cell_op, cell_din
  );

endinterface

// File: rtl/cell_access_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the
// requester that did not win last time.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/cell_access_ctrl.sv
// Arbitrates two requesters onto a bank of single-bit cells, issues one
// select cycle, then follows the cell's valid/rw phases under a watchdog.
module cell_access_ctrl
  import cell_pkg::*;
#(
  parameter int N_CELLS = 16,
  parameter int TIMEOUT = 8
) (
  input logic               clk,
  input logic               rst,
  cell_access_ctrl_if.slave bus
);

  localparam int                 ADDR_W  = addr_width(N_CELLS);
  localparam logic [7:0]         WD_LAST = 8'(TIMEOUT - 1);
  localparam logic [N_CELLS-1:0] SEL_ONE = {{(N_CELLS-1){1'b0}}, 1'b1};

  state_e             state_q;
  logic [1:0]         gnt_q;
  logic [1:0]         done_q;
  logic               err_q;
  logic               rdata_q;
  logic [N_CELLS-1:0] cell_sel_q;
  logic               cell_op_q;
  logic               cell_din_q;
  logic               last_q;
  logic               bad_q;
  logic [7:0]         wd_cnt_q;

  logic [1:0]         win_s;
  logic [ADDR_W-1:0]  win_addr_s;
  logic               win_we_s;
  logic               win_wdata_s;
  logic               win_bad_s;
  logic [1:0]         phase_s;

  rr_arb2 u_arb (
    .req_i  (bus.req),
    .last_i (last_q),
    .gnt_o  (win_s)
  );

  assign win_addr_s  = win_s[1] ? bus.addr1 : bus.addr0;
  assign win_we_s    = win_s[1] ? bus.we[1] : bus.we[0];
  assign win_wdata_s = win_s[1] ? bus.wdata[1] : bus.wdata[0];
  assign win_bad_s   = 32'(win_addr_s) >= 32'(N_CELLS);
  assign phase_s     = {bus.cell_valid, bus.cell_rw};

  // cell_op_q/cell_din_q double as the latched operands of the granted access
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 1'b0;
      rdata_q    <= 1'b0;
      cell_sel_q <= '0;
      cell_op_q  <= 1'b0;
      cell_din_q <= 1'b0;
      last_q     <= 1'b1;
      bad_q      <= 1'b0;
      wd_cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req != 2'b00) begin
            gnt_q      <= win_s;
            last_q     <= win_s[1];
            bad_q      <= win_bad_s;
            cell_op_q  <= win_we_s;
            cell_din_q <= win_wdata_s;
            cell_sel_q <= win_bad_s ? '0 : (SEL_ONE << win_addr_s);
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          cell_sel_q <= '0;
          wd_cnt_q   <= 8'd0;
          if (bad_q) begin
            state_q <= FIN;
            done_q  <= gnt_q;
            err_q   <= 1'b1;
          end else begin
            state_q <= cell_op_q ? WAIT_W : WAIT_R;
          end
        end
        WAIT_W: begin
          // a read phase while writing is a protocol violation by the cell
          if (phase_s == PH_WRITE) begin
            state_q  <= WAIT_S;
            wd_cnt_q <= 8'd0;
          end else if (phase_s == PH_READ || wd_cnt_q == WD_LAST) begin
            state_q <= FIN;
            done_q  <= gnt_q;
            err_q   <= 1'b1;
          end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
          end
        end
        WAIT_S: begin
          if (phase_s == PH_STABLE || wd_cnt_q == WD_LAST) begin
            state_q <= FIN;
            done_q  <= gnt_q;
            err_q   <= (phase_s != PH_STABLE);
          end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
          end
        end
        WAIT_R: begin
          if (phase_s == PH_READ) begin
            rdata_q <= bus.cell_dout;
            state_q <= FIN;
            done_q  <= gnt_q;
            err_q   <= 1'b0;
          end else if (wd_cnt_q == WD_LAST) begin
            state_q <= FIN;
            done_q  <= gnt_q;
            err_q   <= 1'b1;
          end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
          end
        end
        FIN: begin
          done_q  <= 2'b00;
          err_q   <= 1'b0;
          gnt_q   <= 2'b00;
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          gnt_q      <= 2'b00;
          done_q     <= 2'b00;
          err_q      <= 1'b0;
          cell_sel_q <= '0;
        end
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rdata    = rdata_q;
  assign bus.cell_sel = cell_sel_q;
  assign bus.cell_op  = cell_op_q;
  assign bus.cell_din = cell_din_q;

endmodule

// File: tb/tb_cell_access_ctrl.sv
// Directed and randomized transactions against a cycle-count reference
// model of the controller, with the bench acting as the cell array.
module tb_cell_access_ctrl;

  localparam int NC  = 12;
  localparam int TMO = 8;

  logic clk;
  logic rst;
  int   passed;
  int   fails;
  int   total;
  int   last_m;
  logic rdata_m;

  cell_access_ctrl_if #(.N_CELLS(NC)) bus ();

  cell_access_ctrl #(
    .N_CELLS (NC),
    .TIMEOUT (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode: 0 nominal, 1 cell silent, 2 write phase but never stable, 3 read phase during write
  task automatic run_txn(input logic [1:0] rq, input logic [1:0] w, input logic [3:0] a0,
                         input logic [3:0] a1, input logic [1:0] wd, input int mode,
                         input int d1, input int d2, input logic dout, input bit hold);
    int         wi;
    int         dc;
    int         t;
    logic [3:0] a;
    logic       wr;
    logic       bad;
    logic       ok_read;
    logic       err_e;
    logic [1:0] g;
    logic [11:0] one;
    logic [11:0] sel_e;

    if (rq == 2'b11) wi = (last_m == 1) ? 0 : 1;
    else             wi = rq[1] ? 1 : 0;
    last_m  = wi;
    g       = (wi == 1) ? 2'b10 : 2'b01;
    a       = (wi == 1) ? a1 : a0;
    wr      = w[wi];
    bad     = (a >= 4'd12);
    one     = 12'd1;
    sel_e   = bad ? 12'd0 : (one << a);
    ok_read = 1'b0;
    if (bad) begin
      dc = 2; err_e = 1'b1;
    end else if (!wr) begin
      if (mode == 0) begin dc = 3 + d1; err_e = 1'b0; ok_read = 1'b1; end
      else begin dc = 2 + TMO; err_e = 1'b1; end
    end else begin
      case (mode)
        0:       begin dc = 4 + d1 + d2;  err_e = 1'b0; end
        2:       begin dc = 3 + d1 + TMO; err_e = 1'b1; end
        3:       begin dc = 3 + d1;       err_e = 1'b1; end
        default: begin dc = 2 + TMO;      err_e = 1'b1; end
      endcase
    end

    bus.req = rq; bus.we = w; bus.addr0 = a0; bus.addr1 = a1; bus.wdata = wd;
    bus.cell_valid = 1'b0; bus.cell_rw = 1'b0; bus.cell_dout = ~dout;
    step();
    check("gnt", 32'(bus.gnt), 32'(g));
    check("sel_issue", 32'(bus.cell_sel), 32'(sel_e));
    check("done_c1", 32'(bus.done), 32'd0);
    if (!bad) begin
      check("op", 32'(bus.cell_op), 32'(wr));
      check("din", 32'(bus.cell_din), 32'(wd[wi]));
    end
    if (!hold) bus.req = 2'b00;
    for (int k = 2; k <= dc; k++) begin
      step();
      check("sel_zero", 32'(bus.cell_sel), 32'd0);
      if (k == dc) begin
        check("done", 32'(bus.done), 32'(g));
        check("err", 32'(bus.err), 32'(err_e));
        check("rdata", 32'(bus.rdata), 32'(ok_read ? dout : rdata_m));
      end else begin
        check("done_early", 32'(bus.done), 32'd0);
      end
      t = k - 2;
      bus.cell_valid = 1'b0; bus.cell_rw = 1'b0; bus.cell_dout = ~dout;
      if (!bad) begin
        if (!wr) begin
          if (mode == 0 && t == d1) begin bus.cell_valid = 1'b1; bus.cell_dout = dout; end
        end else if (t == d1 && mode != 1) begin
          bus.cell_valid = 1'b1; bus.cell_rw = (mode != 3);
        end else if (mode == 0 && t == d1 + 1 + d2) begin
          bus.cell_rw = 1'b1;
        end
      end
    end
    if (ok_read) rdata_m = dout;
    step();
    check("gnt_clear", 32'(bus.gnt), 32'd0);
    check("done_clear", 32'(bus.done), 32'd0);
    bus.cell_valid = 1'b0; bus.cell_rw = 1'b0;
  endtask

  initial begin
    passed = 0; fails = 0; total = 0; last_m = 1; rdata_m = 1'b0;
    rst = 1'b1;
    bus.req = 2'b00; bus.we = 2'b00; bus.addr0 = 4'd0; bus.addr1 = 4'd0; bus.wdata = 2'b00;
    bus.cell_dout = 1'b0; bus.cell_valid = 1'b0; bus.cell_rw = 1'b0;
    step();
    step();
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_sel", 32'(bus.cell_sel), 32'd0);
    check("rst_op", 32'(bus.cell_op), 32'd0);
    check("rst_din", 32'(bus.cell_din), 32'd0);
    rst = 1'b0;

    // tie held after reset: grants alternate starting with requester 0
    run_txn(2'b11, 2'b00, 4'd2, 4'd3, 2'b00, 0, 0, 0, 1'b1, 1'b1);
    run_txn(2'b11, 2'b00, 4'd2, 4'd3, 2'b00, 0, 1, 0, 1'b0, 1'b1);
    run_txn(2'b11, 2'b00, 4'd2, 4'd3, 2'b00, 0, 0, 0, 1'b1, 1'b0);

    run_txn(2'b01, 2'b01, 4'd5, 4'd0, 2'b01, 0, 0, 0, 1'b0, 1'b0);
    run_txn(2'b10, 2'b00, 4'd0, 4'd3, 2'b00, 0, 0, 0, 1'b1, 1'b0);
    run_txn(2'b01, 2'b00, 4'd4, 4'd0, 2'b00, 1, 0, 0, 1'b0, 1'b0);
    run_txn(2'b01, 2'b01, 4'd13, 4'd0, 2'b01, 0, 0, 0, 1'b0, 1'b0);

    // reset while the write is waiting for its stable phase
    bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 4'd5; bus.wdata = 2'b01;
    step();
    bus.req = 2'b00;
    step();
    bus.cell_valid = 1'b1; bus.cell_rw = 1'b1;
    step();
    bus.cell_valid = 1'b0; bus.cell_rw = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; last_m = 1; rdata_m = 1'b0;
    check("mid_gnt", 32'(bus.gnt), 32'd0);
    check("mid_sel", 32'(bus.cell_sel), 32'd0);
    check("mid_done", 32'(bus.done), 32'd0);
    check("mid_rdata", 32'(bus.rdata), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      check("mid_no_done", 32'(bus.done), 32'd0);
    end
    run_txn(2'b10, 2'b00, 4'd0, 4'd7, 2'b00, 0, 0, 0, 1'b1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int md;
      int x1;
      int x2;
      int r;
      r  = int'($urandom_range(0, 9));
      md = (r <= 6) ? 0 : r - 6;
      x1 = ($urandom_range(0, 7) == 0) ? 7 : int'($urandom_range(0, 3));
      x2 = ($urandom_range(0, 7) == 0) ? 7 : int'($urandom_range(0, 3));
      run_txn(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), md, x1, x2,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    bus.req = 2'b00;
    step();
    check("final_idle_gnt", 32'(bus.gnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
